projectile_engine: RTL

- Multi-slot projectile sprite engine for the 96x64 OLED game layer.
- Holds up to MAX_BALLS fire or water balls, each with its own position and direction. Advances every ball by STEP pixels per frame tick, retires balls that leave the screen or hit the target box, and renders them.
- Rendering has one-cycle latency: the pixel query (X, Y) produces a colour over BACKGROUND. The block sits between the game controller (launch/hit) and the OLED pixel mux.

---
 rtl/proj_pkg.sv | 53 +++++
 rtl/proj_sprite_lookup.sv | 32 +++
 rtl/projectile_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/proj_pkg.sv
// proj_pkg: shared definitions for the projectile sprite engine.
//   - Sprite geometry (SPRITE_W x SPRITE_H = 8x8).
//   - RGB565 colours for the water and fire palettes.
//   - Pixel code enum (TRANSP / OUTLINE / FILL) and kind enum (WATER / FIRE).
//   - SPRITE_ROM: one 16-bit word per row, two bits per pixel, with the
//     leftmost pixel (lx = 0) in the top two bits so each literal reads
//     left to right like the drawn sprite.
//   - code_colour(): maps a pixel code and a kind to an RGB565 colour.
package proj_pkg;

    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 8;

    localparam logic [15:0] WATER_OUTLINE = 16'b00000_000000_10001;
    localparam logic [15:0] WATER_FILL    = 16'b00000_010000_11111;
    localparam logic [15:0] FIRE_OUTLINE  = 16'b11111_000000_00000;
    localparam logic [15:0] FIRE_FILL     = 16'b11111_100110_00000;

    typedef enum logic [1:0] {
        TRANSP  = 2'd0,
        OUTLINE = 2'd1,
        FILL    = 2'd2
    } pix_code_t;

    typedef enum logic {
        WATER = 1'b0,
        FIRE  = 1'b1
    } kind_t;

    // Row 7 first so that SPRITE_ROM[r] is local row r.
    localparam logic [7:0][15:0] SPRITE_ROM = {
        16'b00_00_01_01_01_01_00_00,  // row7 ..OOOO..
        16'b00_01_10_01_10_10_01_00,  // row6 .OFOFFO.
        16'b01_10_10_10_01_10_10_01,  // row5 OFFFOFFO
        16'b01_10_01_10_01_10_10_01,  // row4 OFOFOFFO
        16'b01_10_01_10_01_10_10_01,  // row3 OFOFOFFO
        16'b01_10_10_01_01_10_10_01,  // row2 OFFOOFFO
        16'b00_01_10_10_10_10_01_00,  // row1 .OFFFFO.
        16'b00_00_01_01_01_01_00_00   // row0 ..OOOO..
    };

    function automatic logic [15:0] code_colour(pix_code_t code, kind_t kind);
        logic [15:0] c;
        c = 16'h0000;
        case (code)
            OUTLINE: c = (kind == FIRE) ? FIRE_OUTLINE : WATER_OUTLINE;
            FILL:    c = (kind == FIRE) ? FIRE_FILL    : WATER_FILL;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/proj_sprite_lookup.sv
// proj_sprite_lookup: combinational sprite pixel lookup for one slot.
// Ports:
//   lx, ly  in  3   local column / row inside the 8x8 sprite
//   kind    in  1   0 = water, 1 = fire
//   mirror  in  1   1 = render horizontally mirrored (lx -> 7 - lx)
//   code    out 2   pixel code (TRANSP / OUTLINE / FILL)
//   colour  out 16  RGB565 colour of the pixel (0 when transparent)
module proj_sprite_lookup
    import proj_pkg::*;
(
    input  logic [2:0]  lx,
    input  logic [2:0]  ly,
    input  logic        kind,
    input  logic        mirror,
    output logic [1:0]  code,
    output logic [15:0] colour
);

    logic [2:0]  col;
    logic [15:0] row_bits;
    pix_code_t   pix;

    always_comb begin
        col      = mirror ? (3'd7 - lx) : lx;
        row_bits = SPRITE_ROM[ly];
        // Column 0 lives in bits [15:14], column 7 in bits [1:0].
        pix      = pix_code_t'(row_bits[(4'd14 - {col, 1'b0}) +: 2]);
        code     = pix;
        colour   = code_colour(pix, kind_t'(kind));
    end

endmodule

// File: rtl/projectile_engine.sv
// projectile_engine: multi-slot fire/water ball sprite engine for the
// 96x64 OLED game layer.
// Optional feature macro: PROJ_ANIM_EN (horizontal-mirror animation phase).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_tick            one-cycle pulse per display frame; advances balls
//   launch_valid/ready    launch handshake (ready = some slot is free)
//   launch_x/y/dir/kind   launch position, direction (1 = right), kind (1 = fire)
//   target_x/target_y     top-left of the target hitbox
//   X, Y, BACKGROUND      pixel query and colour under transparent pixels
//   oled_data             registered colour for the (X, Y) sampled last edge
//   active                per-slot active flags
//   hit_mask, hit_kind    one-cycle pulse of slots retired by a target hit,
//                         and the kind of the lowest-index hit slot
module projectile_engine
    import proj_pkg::*;
#(
    parameter int MAX_BALLS = 4,
    parameter int STEP      = 2,
    parameter int SCREEN_W  = 96,
    parameter int TARGET_W  = 12,
    parameter int TARGET_H  = 12,
    parameter int ANIM_DIV  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 launch_valid,
    output logic                 launch_ready,
    input  logic [6:0]           launch_x,
    input  logic [5:0]           launch_y,
    input  logic                 launch_dir,
    input  logic                 launch_kind,
    input  logic [6:0]           target_x,
    input  logic [5:0]           target_y,
    input  logic [6:0]           X,
    input  logic [5:0]           Y,
    input  logic [15:0]          BACKGROUND,
    output logic [15:0]          oled_data,
    output logic [MAX_BALLS-1:0] active,
    output logic [MAX_BALLS-1:0] hit_mask,
    output logic                 hit_kind
);

    if (MAX_BALLS < 1 || MAX_BALLS > 8 || STEP < 1 || STEP > 7 || ANIM_DIV < 1) begin : g_bad_param
        $error("projectile_engine: parameter out of range");
    end

    logic [6:0]           slot_x [MAX_BALLS];
    logic [5:0]           slot_y [MAX_BALLS];
    logic [MAX_BALLS-1:0] slot_dir;
    logic [MAX_BALLS-1:0] slot_kind;

    logic [MAX_BALLS-1:0] free_slots;
    logic [MAX_BALLS-1:0] launch_sel;
    logic [MAX_BALLS-1:0] hit;
    logic [MAX_BALLS-1:0] hit_low;
    logic [MAX_BALLS-1:0] at_edge;
    logic [MAX_BALLS-1:0] opaque;
    logic [15:0]          slot_colour [MAX_BALLS];
    logic [15:0]          pix_nxt;
    logic [7:0]           tx;
    logic [7:0]           ty;
    logic                 mirror;

    assign tx = {1'b0, target_x};
    assign ty = {2'b00, target_y};

    // Lowest set bit of a vector: v & (~v + 1).
    assign free_slots   = ~active;
    assign launch_sel   = free_slots & (~free_slots + 1'b1);
    assign launch_ready = |free_slots;
    assign hit_low      = hit & (~hit + 1'b1);

`ifdef PROJ_ANIM_EN
    localparam int ANIM_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [ANIM_W-1:0] anim_cnt;
    logic              anim_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anim_cnt   <= '0;
            anim_phase <= 1'b0;
        end else if (frame_tick) begin
            if (anim_cnt == ANIM_W'(ANIM_DIV - 1)) begin
                anim_cnt   <= '0;
                anim_phase <= ~anim_phase;
            end else begin
                anim_cnt <= anim_cnt + 1'b1;
            end
        end
    end

    assign mirror = anim_phase;
`else
    assign mirror = 1'b0;
`endif

    // Per-slot collision, edge and render terms, all in 8-bit arithmetic so
    // that a query left of / above the sprite wraps to a large value (outside).
    for (genvar g = 0; g < MAX_BALLS; g++) begin : g_slot
        logic [7:0]  sx;
        logic [7:0]  sy;
        logic [7:0]  lx;
        logic [7:0]  ly;
        logic [1:0]  code;
        logic [15:0] colour;

        assign sx = {1'b0, slot_x[g]};
        assign sy = {2'b00, slot_y[g]};

        assign hit[g] = active[g]
                      && (sx < tx + 8'(TARGET_W)) && (tx < sx + 8'(SPRITE_W))
                      && (sy < ty + 8'(TARGET_H)) && (ty < sy + 8'(SPRITE_H));

        assign at_edge[g] = slot_dir[g] ? (sx + 8'(STEP) > 8'(SCREEN_W - SPRITE_W))
                                        : (sx < 8'(STEP));

        assign lx = {1'b0, X} - sx;
        assign ly = {2'b00, Y} - sy;

        proj_sprite_lookup u_lookup (
            .lx     (lx[2:0]),
            .ly     (ly[2:0]),
            .kind   (slot_kind[g]),
            .mirror (mirror),
            .code   (code),
            .colour (colour)
        );

        assign opaque[g] = active[g] && (lx < 8'(SPRITE_W)) && (ly < 8'(SPRITE_H))
                         && (pix_code_t'(code) != TRANSP);
        assign slot_colour[g] = colour;
    end

    // Lowest-index opaque slot wins; scanning downwards lets it overwrite last.
    always_comb begin
        pix_nxt = BACKGROUND;
        for (int i = MAX_BALLS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                pix_nxt = slot_colour[i];
            end
        end
    end

    // Slot state: launch loads a free slot; a tick moves or retires the slots
    // that were already active, so a slot launched this edge is never moved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= '0;
            slot_dir  <= '0;
            slot_kind <= '0;
            for (int i = 0; i < MAX_BALLS; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_BALLS; i++) begin
                if (launch_valid && launch_sel[i]) begin
                    active[i]    <= 1'b1;
                    slot_x[i]    <= launch_x;
                    slot_y[i]    <= launch_y;
                    slot_dir[i]  <= launch_dir;
                    slot_kind[i] <= launch_kind;
                end else if (frame_tick && active[i]) begin
                    if (hit[i] || at_edge[i]) begin
                        active[i] <= 1'b0;
                    end else if (slot_dir[i]) begin
                        slot_x[i] <= slot_x[i] + 7'(STEP);
                    end else begin
                        slot_x[i] <= slot_x[i] - 7'(STEP);
                    end
                end
            end
        end
    end

    // Output stage: hit report and registered pixel colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_mask  <= '0;
            hit_kind  <= 1'b0;
            oled_data <= 16'h0000;
        end else begin
            hit_mask  <= frame_tick ? hit : '0;
            if (frame_tick && (|hit)) begin
                hit_kind <= |(hit_low & slot_kind);
            end
            oled_data <= pix_nxt;
        end
    end

endmodule
